// File: rtl/fifo_tg_pkg.sv
// fifo_tg_pkg: shared FSM states and LFSR constants for the FIFO traffic generator.
package fifo_tg_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam int LFSR_W = 16;
    // Right-shifting Fibonacci form of taps 16,14,13,11 (state bits 0,2,3,5).
    localparam logic [LFSR_W-1:0] TAP_MASK = 16'h002D;
endpackage

// File: rtl/tg_lfsr.sv
// tg_lfsr: 16-bit Fibonacci LFSR that steps only when advance is high.
module tg_lfsr
    import fifo_tg_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    output logic [LFSR_W-1:0] state
);
    always_ff @(posedge clk)
        if (!rst) state <= SEED;
        else if (advance) state <= {^(state & TAP_MASK), state[LFSR_W-1:1]};
endmodule

// File: rtl/fifo_traffic_gen.sv
// fifo_traffic_gen: drives a FIFO with pseudo-random push/pop traffic, then drains it
// and cross-checks the FIFO flags against an internal occupancy count.
module fifo_traffic_gen
    import fifo_tg_pkg::*;
#(
    parameter int                WIDTH     = 8,
    parameter int                DEPTH     = 4,
    parameter int                NUM_OPS   = 64,
    parameter int                START_IDX = 3,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             empty,
    input  logic             full,
    output logic             push,
    output logic             pop,
    output logic [WIDTH-1:0] data_in,
    output logic             start,
    output logic             busy,
    output logic             done,
    output logic             occ_err
);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(NUM_OPS + 1);
    localparam logic [OW-1:0]    OCC_FULL  = OW'(DEPTH);
    localparam logic [CW-1:0]    LAST_OP   = CW'(NUM_OPS - 1);
    localparam logic [WIDTH-1:0] START_SEQ = WIDTH'(START_IDX);

    state_t            state;
    logic [OW-1:0]     occ;
    logic [CW-1:0]     ops;
    logic [WIDTH-1:0]  seq;
    logic              start_sent;
    logic [LFSR_W-1:0] lfsr;
    logic              run;
    logic              drain;

    assign run     = state == RUN;
    assign drain   = state == DRAIN;
    assign busy    = run | drain;
    assign done    = state == DONE;
    assign data_in = seq;

    tg_lfsr #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (run),
        .state   (lfsr)
    );

    // Strobes react to the flags in the same cycle and are gated by reset so a
    // reset edge never coincides with a FIFO access.
    always_comb begin
        push  = rst & run & lfsr[0] & ~full;
        pop   = rst & ((run & lfsr[1]) | drain) & ~empty;
        start = push & (seq == START_SEQ) & ~start_sent;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            occ        <= '0;
            ops        <= '0;
            seq        <= '0;
            start_sent <= 1'b0;
            occ_err    <= 1'b0;
        end else begin
            if (busy && (((occ == '0) != empty) || ((occ == OCC_FULL) != full))) occ_err <= 1'b1;
            if (push && !pop) occ <= occ + 1'b1;
            else if (pop && !push) occ <= occ - 1'b1;
            if (push) seq <= seq + 1'b1;
            if (start) start_sent <= 1'b1;
            case (state)
                IDLE: begin
                    occ        <= '0;
                    ops        <= '0;
                    seq        <= '0;
                    start_sent <= 1'b0;
                    if (enable) state <= RUN;
                end
                RUN: begin
                    ops <= ops + 1'b1;
                    if (ops == LAST_OP) state <= DRAIN;
                end
                DRAIN:   if (empty) state <= DONE;
                DONE:    if (!enable) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fifo_traffic_gen.md
FIFO_TRAFFIC_GEN -- requirements
Module: fifo_traffic_gen

Interface
REQ-001 WIDTH, `WIDTH, data word width in bits.
REQ-002 DEPTH, `DEPTH, capacity of the driven FIFO in words.
REQ-003 NUM_OPS, 64, number of RUN-phase cycles (>=1).
REQ-004 START_IDX, 3, sequence number of the word marked with start (0 <= START_IDX < 2**WIDTH).
REQ-005 SEED, 16'hACE1, LFSR reset value (nonzero).
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-low reset (rst==0 resets on the clk edge).
REQ-008 enable  input  1  level request to run one traffic session.
REQ-009 empty  input  1  FIFO empty flag.
REQ-010 full  input  1  FIFO full flag.
REQ-011 push  output  1  FIFO write strobe.
REQ-012 pop  output  1  FIFO read strobe.
REQ-013 data_in  output  WIDTH  word written on push (drives FIFO data_in).
REQ-014 start  output  1  one-cycle tag accompanying the push of sequence number START_IDX.
REQ-015 busy  output  1  high in RUN or DRAIN.
REQ-016 done  output  1  high in DONE.
REQ-017 occ_err  output  1  sticky flag: internal occupancy disagrees with empty/full.

Function
REQ-018 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN when enable=1; RUN->DRAIN after exactly NUM_OPS RUN cycles; DRAIN->DONE in the cycle after a cycle in which empty=1; DONE->IDLE when enable=0.
REQ-019 16-bit Fibonacci LFSR (taps 16,14,13,11) advances once per RUN cycle; bit0 = push_req, bit1 = pop_req, held otherwise.
REQ-020 RUN: push = push_req & ~full; pop = pop_req & ~empty (combinational on full/empty, zero latency); push and pop may both be high in one cycle.
REQ-021 DRAIN: push=0; pop = ~empty every cycle.
REQ-022 IDLE, DONE: push=0, pop=0.
REQ-023 push SHALL never be high while full=1; pop SHALL never be high while empty=1, in any state.
REQ-024 data_in = seq counter (WIDTH bits, starts 0 each session, +1 per accepted push, wraps modulo 2**WIDTH).
REQ-025 start = push & (seq == START_IDX) & ~start_sent; start_sent sets on that push and clears in IDLE; at most one start per session.
REQ-026 occ counter 0..DEPTH: +1 on push only, -1 on pop only, unchanged on both or neither; cleared in IDLE.
REQ-027 occ_err sets on any cycle where (occ==0)!=empty or (occ==DEPTH)!=full while busy; cleared only by reset.
REQ-028 enable deasserted during RUN/DRAIN does not abort; session completes.

Reset
REQ-029 rst=0: state=IDLE, push=0, pop=0, start=0, data_in=0, busy=0, done=0, occ_err=0, occ=0, seq=0, start_sent=0, LFSR=SEED.
REQ-030 rst=0 mid-session returns to IDLE on that edge; no push/pop in that cycle.

Structure
REQ-031 Shared package fifo_tg_pkg: state enum, LFSR width, tap mask constant.
REQ-032 One sub-module tg_lfsr (SEED param, advance enable, 16-bit state out).
REQ-033 Counters sized $clog2(DEPTH+1) for occ and $clog2(NUM_OPS+1) for run cycles.

Verification
REQ-034 Reset 2 cycles, then enable=1 with full=empty tied to an ideal DEPTH=4 FIFO -> busy next cycle, done after NUM_OPS+drain cycles, occ_err=0.
REQ-035 full held 1 during RUN -> push never asserted, seq stays 0.
REQ-036 Ideal FIFO, START_IDX=3 -> start high exactly once, coincident with push of data_in=3.
REQ-037 empty forced 0 while FIFO model holds 0 words -> occ_err=1 and stays 1 until rst=0.
REQ-038 rst=0 asserted mid-RUN -> next cycle state IDLE, all outputs 0, LFSR=SEED.
REQ-039 WIDTH=2, >4 pushes in one session -> data_in sequence 0,1,2,3,0,...; consumer sees in-order words.
